// File: rtl/path_reader.sv
// path_reader: walks a predecessor ("prev") array in memory from the
// destination back to the source, streaming each visited node out
// destination-first, and reports NO_PATH / RANGE / LOOP conditions.
module path_reader #(
  parameter int MAX_NODES   = 64,
  parameter int INDEX_WIDTH = 8,
  parameter int MADDR_WIDTH = 32,
  parameter int MDATA_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [INDEX_WIDTH-1:0] source,
  input  logic [INDEX_WIDTH-1:0] destination,
  input  logic [INDEX_WIDTH-1:0] number_of_nodes,
  input  logic [MADDR_WIDTH-1:0] base_address,
  output logic                   mem_read_enable,
  output logic [MADDR_WIDTH-1:0] mem_addr,
  input  logic                   wait_request,
  input  logic                   mem_read_ready,
  input  logic [MDATA_WIDTH-1:0] mem_read_data,
  output logic                   path_valid,
  input  logic                   path_ready,
  output logic [INDEX_WIDTH-1:0] path_node,
  output logic                   path_last,
  output logic [INDEX_WIDTH-1:0] path_length,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             error
);

  localparam logic [INDEX_WIDTH-1:0] NO_PREVIOUS_NODE = '1;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_NO_PATH = 2'd1;
  localparam logic [1:0] ERR_RANGE   = 2'd2;
  localparam logic [1:0] ERR_LOOP    = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    EMIT,
    FETCH,
    WAIT_DATA,
    CHECK,
    DONE
  } state_t;

  state_t                 state;
  logic [INDEX_WIDTH-1:0] cur;
  logic [INDEX_WIDTH-1:0] src;
  logic [INDEX_WIDTH-1:0] num_nodes;
  logic [INDEX_WIDTH-1:0] prev;
  logic [MADDR_WIDTH-1:0] base;
  logic [MADDR_WIDTH-1:0] prev_base;
  logic [MADDR_WIDTH-1:0] fetch_addr;
  logic                   range_bad;

  // The prev array sits right after the N*N word matrix; all address math wraps.
  assign prev_base  = base + ((MADDR_WIDTH'(num_nodes) * MADDR_WIDTH'(num_nodes)) << 2);
  assign fetch_addr = prev_base + (MADDR_WIDTH'(cur) << 2);

  // Request arguments are screened before any beat or read is produced.
  assign range_bad = (source >= number_of_nodes) || (destination >= number_of_nodes) ||
                     (32'(number_of_nodes) > MAX_NODES);

  // Only the low INDEX_WIDTH bits of a memory word carry the prev entry.
  generate
    if (MDATA_WIDTH > INDEX_WIDTH) begin : g_unused
      logic unused_data;
      assign unused_data = ^mem_read_data[MDATA_WIDTH-1:INDEX_WIDTH];
    end
  endgenerate

  // Path-walk controller; every output is a register updated here.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      cur             <= '0;
      src             <= '0;
      num_nodes       <= '0;
      prev            <= '0;
      base            <= '0;
      mem_read_enable <= 1'b0;
      mem_addr        <= '0;
      path_valid      <= 1'b0;
      path_node       <= '0;
      path_last       <= 1'b0;
      path_length     <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= ERR_OK;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            src         <= source;
            num_nodes   <= number_of_nodes;
            base        <= base_address;
            cur         <= destination;
            path_length <= '0;
            if (range_bad) begin
              error <= ERR_RANGE;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              error      <= ERR_OK;
              busy       <= 1'b1;
              path_valid <= 1'b1;
              path_node  <= destination;
              path_last  <= (destination == source);
              state      <= EMIT;
            end
          end
        end

        EMIT: begin
          // path_valid is high for the whole of EMIT; node/last stay put until accepted.
          if (path_ready) begin
            path_valid  <= 1'b0;
            path_last   <= 1'b0;
            path_length <= path_length + INDEX_WIDTH'(1);
            if (cur == src) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              mem_read_enable <= 1'b1;
              mem_addr        <= fetch_addr;
              state           <= FETCH;
            end
          end
        end

        FETCH: begin
          if (!wait_request) begin
            mem_read_enable <= 1'b0;
            if (mem_read_ready) begin
              prev  <= mem_read_data[INDEX_WIDTH-1:0];
              state <= CHECK;
            end else begin
              state <= WAIT_DATA;
            end
          end
        end

        WAIT_DATA: begin
          if (mem_read_ready) begin
            prev  <= mem_read_data[INDEX_WIDTH-1:0];
            state <= CHECK;
          end
        end

        CHECK: begin
          if (prev == NO_PREVIOUS_NODE) begin
            error <= ERR_NO_PATH;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (prev >= num_nodes) begin
            error <= ERR_RANGE;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (path_length >= num_nodes) begin
            // More beats than nodes means the prev chain cycles.
            error <= ERR_LOOP;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cur        <= prev;
            path_valid <= 1'b1;
            path_node  <= prev;
            path_last  <= (prev == src);
            state      <= EMIT;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_path_reader.sv
// Randomized self-checking bench for path_reader: a memory responder with
// configurable wait states and read latency, a stream sink with backpressure,
// and a reference model that walks the prev array directly.
module tb_path_reader;
  localparam int IW = 8;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [IW-1:0] source = '0;
  logic [IW-1:0] destination = '0;
  logic [IW-1:0] number_of_nodes = '0;
  logic [AW-1:0] base_address = '0;
  logic          mem_read_enable;
  logic [AW-1:0] mem_addr;
  logic          wait_request = 1'b0;
  logic          mem_read_ready = 1'b0;
  logic [DW-1:0] mem_read_data = '0;
  logic          path_valid;
  logic          path_ready = 1'b0;
  logic [IW-1:0] path_node;
  logic          path_last;
  logic [IW-1:0] path_length;
  logic          busy;
  logic          done;
  logic [1:0]    error;

  path_reader dut (
    .clock(clock), .reset(reset), .start(start),
    .source(source), .destination(destination),
    .number_of_nodes(number_of_nodes), .base_address(base_address),
    .mem_read_enable(mem_read_enable), .mem_addr(mem_addr),
    .wait_request(wait_request), .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data),
    .path_valid(path_valid), .path_ready(path_ready),
    .path_node(path_node), .path_last(path_last),
    .path_length(path_length), .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory image and responder configuration
  logic [IW-1:0] prev_mem [0:255];
  int            cfg_wait = 0;
  int            cfg_lat  = 1;
  logic [AW-1:0] cur_pb   = '0;
  logic [AW-1:0] got_addrs [$];

  bit            rsp_in_req  = 1'b0;
  int            rsp_wait    = 0;
  bit            rsp_pending = 1'b0;
  int            rsp_lat     = 0;
  logic [DW-1:0] rsp_data    = '0;
  logic [AW-1:0] rsp_addr    = '0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [AW-1:0] off;
    logic [DW-1:0] w;
    off = (a - cur_pb) >> 2;
    w   = $urandom();
    if (off < 256) w[IW-1:0] = prev_mem[off[7:0]];
    return w;
  endfunction

  // Memory responder: wait states per request, then data after cfg_lat cycles (0 = same cycle).
  initial begin
    forever begin
      @(negedge clock);
      mem_read_ready = 1'b0;
      if (rsp_pending) begin
        if (rsp_lat == 0) begin
          mem_read_ready = 1'b1;
          mem_read_data  = rsp_data;
          rsp_pending    = 1'b0;
        end else begin
          rsp_lat--;
        end
      end
      if (!mem_read_enable) begin
        rsp_in_req   = 1'b0;
        wait_request = 1'b0;
      end else begin
        if (!rsp_in_req) begin
          rsp_in_req = 1'b1;
          rsp_wait   = cfg_wait;
          rsp_addr   = mem_addr;
        end else begin
          check_value("addr_hold", 64'(mem_addr), 64'(rsp_addr));
        end
        if (rsp_wait > 0) begin
          wait_request = 1'b1;
          rsp_wait--;
        end else begin
          wait_request = 1'b0;
          rsp_in_req   = 1'b0;
          got_addrs.push_back(mem_addr);
          rsp_data = mem_word(mem_addr);
          if (cfg_lat == 0) begin
            mem_read_ready = 1'b1;
            mem_read_data  = rsp_data;
          end else begin
            rsp_pending = 1'b1;
            rsp_lat     = cfg_lat - 1;
          end
        end
      end
    end
  end

  // Reference model: follow prev links from dst toward src
  logic [IW-1:0] exp_nodes [$];
  logic [AW-1:0] exp_addrs [$];
  int            exp_err;
  int            exp_len;
  bit            exp_range;

  task automatic model(input int src, input int dst, input int n, input logic [AW-1:0] base);
    int cur;
    logic [AW-1:0] pb;
    exp_nodes.delete();
    exp_addrs.delete();
    exp_err   = 0;
    exp_len   = 0;
    exp_range = (src >= n) || (dst >= n) || (n > 64);
    pb = base + AW'(n * n * 4);
    if (exp_range) begin
      exp_err = 2;
      return;
    end
    cur = dst;
    for (int k = 0; k < 512; k++) begin
      exp_nodes.push_back(IW'(cur));
      exp_len++;
      if (cur == src) return;
      exp_addrs.push_back(pb + AW'(cur * 4));
      if (prev_mem[cur] == 8'hFF) begin exp_err = 1; return; end
      if (int'(prev_mem[cur]) >= n) begin exp_err = 2; return; end
      if (exp_len >= n) begin exp_err = 3; return; end
      cur = int'(prev_mem[cur]);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) prev_mem[i] = 8'hFF;
  endtask

  // One full run: issue start, sink beats, then compare everything against the model.
  task automatic run(input string name, input int src, input int dst, input int n,
                     input logic [AW-1:0] base, input int bp, input bit rnd_ready);
    logic [IW-1:0] got_nodes [$];
    logic          got_last [$];
    int            cyc = 0;
    int            hold = 0;
    bit            pend = 1'b0;
    bit            finished = 1'b0;
    bit            r;
    logic [IW-1:0] pend_node = '0;
    logic          pend_last = 1'b0;

    model(src, dst, n, base);
    got_addrs.delete();
    cur_pb = base + AW'(n * n * 4);
    @(negedge clock);
    source          = IW'(src);
    destination     = IW'(dst);
    number_of_nodes = IW'(n);
    base_address    = base;
    start           = 1'b1;
    path_ready      = 1'b0;
    @(negedge clock);
    start = 1'b0;
    source = IW'($urandom());
    destination = IW'($urandom());
    check_value({name, ":busy"}, 64'(busy), exp_range ? 64'd0 : 64'd1);
    while (!finished && cyc < 3000) begin
      if (path_valid || mem_read_enable)
        check_value({name, ":excl"}, 64'(path_valid & mem_read_enable), 64'd0);
      if (done) begin
        finished = 1'b1;
      end else begin
        if (path_valid) begin
          if (pend) begin
            check_value({name, ":hold_node"}, 64'(path_node), 64'(pend_node));
            check_value({name, ":hold_last"}, 64'(path_last), 64'(pend_last));
          end else begin
            pend = 1'b1;
            pend_node = path_node;
            pend_last = path_last;
            hold = bp;
          end
          if (rnd_ready) r = 1'($urandom_range(0, 1));
          else           r = (hold == 0);
          if (hold > 0) hold--;
          path_ready = r;
          if (r) begin
            got_nodes.push_back(path_node);
            got_last.push_back(path_last);
            pend = 1'b0;
          end
        end else begin
          path_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        @(negedge clock);
        cyc++;
      end
    end
    path_ready = 1'b0;
    check_value({name, ":finished"}, 64'(finished), 64'd1);
    check_value({name, ":error"}, 64'(error), 64'(exp_err));
    check_value({name, ":path_length"}, 64'(path_length), 64'(exp_len));
    check_value({name, ":beats"}, 64'(got_nodes.size()), 64'(exp_nodes.size()));
    for (int i = 0; i < got_nodes.size() && i < exp_nodes.size(); i++) begin
      check_value($sformatf("%s:node%0d", name, i), 64'(got_nodes[i]), 64'(exp_nodes[i]));
      check_value($sformatf("%s:last%0d", name, i), 64'(got_last[i]),
                  64'(exp_nodes[i] == IW'(src)));
    end
    check_value({name, ":reads"}, 64'(got_addrs.size()), 64'(exp_addrs.size()));
    for (int i = 0; i < got_addrs.size() && i < exp_addrs.size(); i++)
      check_value($sformatf("%s:addr%0d", name, i), 64'(got_addrs[i]), 64'(exp_addrs[i]));
    @(negedge clock);
    check_value({name, ":done_pulse"}, 64'(done), 64'd0);
    check_value({name, ":busy_after"}, 64'(busy), 64'd0);
    $display("run %s src=%0d dst=%0d n=%0d beats=%0d reads=%0d err=%0d len=%0d",
             name, src, dst, n, got_nodes.size(), got_addrs.size(), error, path_length);
  endtask

  function automatic logic [63:0] all_outputs();
    return 64'({mem_read_enable, mem_addr, path_valid, path_node, path_last,
                path_length, busy, done, error});
  endfunction

  task automatic nominal_graph();
    clear_mem();
    prev_mem[3] = 8'd1;
    prev_mem[1] = 8'd0;
  endtask

  // Reset while waiting on read data; the late response must not revive the run.
  task automatic reset_test();
    int  cyc = 0;
    bit  reached = 1'b0;
    nominal_graph();
    cfg_wait = 0;
    cfg_lat  = 10;
    got_addrs.delete();
    cur_pb = 32'h1040;
    @(negedge clock);
    source = 8'd0; destination = 8'd3; number_of_nodes = 8'd4;
    base_address = 32'h1000; start = 1'b1; path_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    while (!reached && cyc < 50) begin
      if (got_addrs.size() == 1 && !mem_read_enable) reached = 1'b1;
      else begin
        @(negedge clock);
        cyc++;
      end
    end
    check_value("rst:reach_wait", 64'(reached), 64'd1);
    reset = 1'b0;
    #1;
    check_value("rst:async_outputs", all_outputs(), 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      check_value($sformatf("rst:quiet%0d", i),
                  64'({path_valid, busy, mem_read_enable, done}), 64'd0);
    end
    path_ready = 1'b0;
    $display("run reset_in_wait_data late_ready_ignored outputs=%0h", all_outputs());
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_mem();
    repeat (3) @(negedge clock);
    check_value("reset:outputs", all_outputs(), 64'd0);
    reset = 1'b1;
    @(negedge clock);

    nominal_graph();
    cfg_wait = 0; cfg_lat = 1;
    run("nominal", 0, 3, 4, 32'h1000, 0, 1'b0);
    check_value("nominal:addr_lit0", 64'(got_addrs.size() > 0 ? got_addrs[0] : '0), 64'h104C);
    check_value("nominal:addr_lit1", 64'(got_addrs.size() > 1 ? got_addrs[1] : '0), 64'h1044);

    run("backpressure", 0, 3, 4, 32'h1000, 5, 1'b0);
    cfg_wait = 3;
    run("wait_states", 0, 3, 4, 32'h1000, 0, 1'b0);
    cfg_wait = 0; cfg_lat = 0;
    run("same_cycle_data", 0, 3, 4, 32'h1000, 0, 1'b0);
    cfg_lat = 2;

    clear_mem();
    run("no_path", 0, 3, 4, 32'h1000, 0, 1'b0);
    run("range_dst", 0, 7, 4, 32'h1000, 0, 1'b0);
    run("range_n", 0, 1, 70, 32'h1000, 0, 1'b0);
    prev_mem[3] = 8'd2;
    prev_mem[2] = 8'd3;
    run("loop", 0, 3, 4, 32'h1000, 1, 1'b0);
    run("src_eq_dst", 2, 2, 4, 32'h1000, 0, 1'b0);
    prev_mem[3] = 8'd9;
    run("prev_range", 0, 3, 4, 32'hFFFF_FFF0, 0, 1'b0);

    reset_test();
    nominal_graph();
    cfg_lat = 1;
    run("after_reset", 0, 3, 4, 32'h1000, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      int n, src, dst, sel;
      n = (($urandom_range(0, 9) == 0) ? $urandom_range(65, 70) : $urandom_range(1, 10));
      clear_mem();
      for (int i = 0; i < n; i++) begin
        sel = $urandom_range(0, 19);
        if (sel == 0)      prev_mem[i] = 8'hFF;
        else if (sel == 1) prev_mem[i] = IW'(n + $urandom_range(0, 5));
        else               prev_mem[i] = IW'($urandom_range(0, n - 1));
      end
      src = $urandom_range(0, n - 1);
      dst = ($urandom_range(0, 9) == 0) ? n + 1 : $urandom_range(0, n - 1);
      cfg_wait = $urandom_range(0, 3);
      cfg_lat  = $urandom_range(0, 3);
      run($sformatf("rand%0d", t), src, dst, n, AW'($urandom()),
          $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
